// File: rtl/reg_file_seq_pkg.sv
// Shared types for the register-file sequencer: FSM states, reserved opcodes and the
// packed instruction layout {op, rd, rs1, rs2}.
package reg_file_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_t;

endpackage

// File: rtl/reg_file_seq_if.sv
// Instruction handshake plus register-file/ALU control bundle between the instruction
// source (master) and reg_file_seq (slave).
interface reg_file_seq_if
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
);

    logic              instr_valid;
    logic              instr_ready;
    instr_t            instr;
    logic              wb_stall;
    logic [ADDR_W-1:0] RA1;
    logic [ADDR_W-1:0] RA2;
    logic [ADDR_W-1:0] WA;
    logic              write_enable;
    logic [3:0]        alu_op;
    logic              alu_start;
    logic              done;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        output instr_valid, instr, wb_stall,
        input  instr_ready, RA1, RA2, WA, write_enable, alu_op, alu_start,
               done, busy, halted, instr_count
    );

    modport slave (
        input  instr_valid, instr, wb_stall,
        output instr_ready, RA1, RA2, WA, write_enable, alu_op, alu_start,
               done, busy, halted, instr_count
    );

endinterface

// File: rtl/reg_file_seq.sv
// Multi-cycle sequencer: accepts one instruction per handshake and steps it through
// operand read, ALU execution and a stall-able write-back into the register file.
module reg_file_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_seq_if.slave bus
);

    if (ALU_LAT < 1 || ALU_LAT > 7 || DATA_W < 1) begin : g_bad_params
        $error("reg_file_seq: ALU_LAT must be within 1..7 and DATA_W positive");
    end

    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ra1_q, ra1_d;
    logic [ADDR_W-1:0] ra2_q, ra2_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              alu_start_q, alu_start_d;
    logic              write_enable_q, write_enable_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;

    instr_t instr_in;
    logic   instr_ready;
    logic   accept;
    logic   is_alu_op;

    assign instr_in    = bus.instr;
    assign instr_ready = (state_q == IDLE);
    assign accept      = bus.instr_valid && instr_ready;
    assign is_alu_op   = (instr_in.op != OP_NOP) && (instr_in.op != OP_HALT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (instr_in.op == OP_HALT) begin
                        state_d = HALTED;
                    end else if (instr_in.op != OP_NOP) begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = EXEC;
            EXEC:    if (lat_cnt_q == 3'd0) state_d = WB;
            // Leave write-back only after the cycle that actually carried the write strobe.
            WB:      if (write_enable_q) state_d = IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ra1_d          = ra1_q;
        ra2_d          = ra2_q;
        wa_d           = wa_q;
        rd_d           = rd_q;
        alu_op_d       = alu_op_q;
        alu_start_d    = 1'b0;
        write_enable_d = 1'b0;
        done_d         = 1'b0;
        lat_cnt_d      = lat_cnt_q;
        instr_count_d  = instr_count_q;
        busy_d         = (state_d == READ) || (state_d == EXEC) || (state_d == WB);
        halted_d       = (state_d == HALTED);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_alu_op) begin
                        ra1_d       = ADDR_W'(instr_in.rs1);
                        ra2_d       = ADDR_W'(instr_in.rs2);
                        rd_d        = ADDR_W'(instr_in.rd);
                        alu_op_d    = instr_in.op;
                        alu_start_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: lat_cnt_d = LAT_INIT;
            EXEC: begin
                if (lat_cnt_q != 3'd0) begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end else begin
                    wa_d           = rd_q;
                    write_enable_d = !bus.wb_stall;
                    done_d         = !bus.wb_stall;
                end
            end
            WB: begin
                if (!write_enable_q) begin
                    write_enable_d = !bus.wb_stall;
                    done_d         = !bus.wb_stall;
                end
            end
            default: ;
        endcase
        if (done_d) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra1_q          <= '0;
            ra2_q          <= '0;
            wa_q           <= '0;
            rd_q           <= '0;
            alu_op_q       <= '0;
            alu_start_q    <= 1'b0;
            write_enable_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
            halted_q       <= 1'b0;
            lat_cnt_q      <= '0;
            instr_count_q  <= '0;
        end else begin
            ra1_q          <= ra1_d;
            ra2_q          <= ra2_d;
            wa_q           <= wa_d;
            rd_q           <= rd_d;
            alu_op_q       <= alu_op_d;
            alu_start_q    <= alu_start_d;
            write_enable_q <= write_enable_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
            halted_q       <= halted_d;
            lat_cnt_q      <= lat_cnt_d;
            instr_count_q  <= instr_count_d;
        end
    end

    assign bus.instr_ready  = instr_ready;
    assign bus.RA1          = ra1_q;
    assign bus.RA2          = ra2_q;
    assign bus.WA           = wa_q;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_start    = alu_start_q;
    assign bus.write_enable = write_enable_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.halted       = halted_q;
    assign bus.instr_count  = instr_count_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Bench for reg_file_seq: two instances (ALU latency 1 and 3) driven with directed
// instructions; retire pulses are checked against a queue of expected results.
module tb_reg_file_seq;
    import reg_file_pkg::*;

    typedef struct packed {
        logic       we;
        logic [3:0] wa;
        logic [7:0] cnt;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [3:0] op;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;

    int vectors     = 0;
    int miscompares = 0;
    int wePulses1   = 0;
    int wePulses3   = 0;
    exp_t exp1[$];
    exp_t exp3[$];
    exp_t e1;
    exp_t e3;

    always #5 clk = ~clk;

    reg_file_seq_if #(.ADDR_W(4), .CNT_W(8)) if1 ();
    reg_file_seq_if #(.ADDR_W(4), .CNT_W(8)) if3 ();

    reg_file_seq #(.ADDR_W(4), .DATA_W(8), .ALU_LAT(1), .CNT_W(8)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (if1)
    );

    reg_file_seq #(.ADDR_W(4), .DATA_W(8), .ALU_LAT(3), .CNT_W(8)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (if3)
    );

    function automatic exp_t mkExp(input logic we, input logic [3:0] wa, input logic [7:0] cnt,
                                   input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] op);
        exp_t e;
        e.we  = we;
        e.wa  = wa;
        e.cnt = cnt;
        e.ra1 = ra1;
        e.ra2 = ra2;
        e.op  = op;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Offers one instruction to the latency-1 instance; returns just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] word, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        if1.instr       = word;
        if1.instr_valid = 1'b1;
        while (!if1.instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("handshake within bound", waited < 50, 1);
        if (waited < 50) exp1.push_back(e);
        @(posedge clk);
        #1 if1.instr_valid = 1'b0;
    endtask

    // Scoreboard monitors: every retire pulse consumes one expected result.
    always @(negedge clk) begin
        if (if1.write_enable === 1'b1) begin
            wePulses1++;
            checkOutput("dut1 done with write", if1.done, 1);
        end
        if (if1.done === 1'b1) begin
            checkOutput("dut1 done expected", exp1.size() > 0, 1);
            if (exp1.size() > 0) begin
                e1 = exp1.pop_front();
                checkOutput("dut1 write_enable at done", if1.write_enable, e1.we);
                checkOutput("dut1 instr_count at done", if1.instr_count, e1.cnt);
                if (e1.we) begin
                    checkOutput("dut1 WA at done", if1.WA, e1.wa);
                    checkOutput("dut1 RA1 at done", if1.RA1, e1.ra1);
                    checkOutput("dut1 RA2 at done", if1.RA2, e1.ra2);
                    checkOutput("dut1 alu_op at done", if1.alu_op, e1.op);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (if3.write_enable === 1'b1) begin
            wePulses3++;
            checkOutput("dut3 done with write", if3.done, 1);
        end
        if (if3.done === 1'b1) begin
            checkOutput("dut3 done expected", exp3.size() > 0, 1);
            if (exp3.size() > 0) begin
                e3 = exp3.pop_front();
                checkOutput("dut3 write_enable at done", if3.write_enable, e3.we);
                checkOutput("dut3 instr_count at done", if3.instr_count, e3.cnt);
                if (e3.we) begin
                    checkOutput("dut3 WA at done", if3.WA, e3.wa);
                    checkOutput("dut3 RA1 at done", if3.RA1, e3.ra1);
                    checkOutput("dut3 RA2 at done", if3.RA2, e3.ra2);
                    checkOutput("dut3 alu_op at done", if3.alu_op, e3.op);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pre;
        int wrote;
        int notReady;

        if1.instr_valid = 1'b0;
        if1.instr       = '0;
        if1.wb_stall    = 1'b0;
        if3.instr_valid = 1'b0;
        if3.instr       = '0;
        if3.wb_stall    = 1'b0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset instr_ready", if1.instr_ready, 1);
        checkOutput("reset busy", if1.busy, 0);
        checkOutput("reset halted", if1.halted, 0);
        checkOutput("reset instr_count", if1.instr_count, 0);
        checkOutput("reset write_enable", if1.write_enable, 0);
        checkOutput("reset alu_start", if1.alu_start, 0);
        checkOutput("reset done", if1.done, 0);
        checkOutput("reset addresses", {if1.RA1, if1.RA2, if1.WA, if1.alu_op}, 0);
        checkOutput("reset dut3 instr_count", if3.instr_count, 0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        $display("[TB] basic ALU instruction, latency 1");
        applyStimulus(16'h1A12, mkExp(1'b1, 4'hA, 8'd1, 4'h1, 4'h2, 4'h1));
        @(negedge clk);
        checkOutput("t1 c1 alu_start", if1.alu_start, 1);
        checkOutput("t1 c1 RA1", if1.RA1, 1);
        checkOutput("t1 c1 RA2", if1.RA2, 2);
        checkOutput("t1 c1 alu_op", if1.alu_op, 1);
        checkOutput("t1 c1 instr_ready", if1.instr_ready, 0);
        checkOutput("t1 c1 busy", if1.busy, 1);
        @(negedge clk);
        checkOutput("t1 c2 alu_start", if1.alu_start, 0);
        checkOutput("t1 c2 write_enable", if1.write_enable, 0);
        @(negedge clk);
        checkOutput("t1 c3 write_enable", if1.write_enable, 1);
        checkOutput("t1 c3 WA", if1.WA, 4'hA);
        checkOutput("t1 c3 done", if1.done, 1);
        @(negedge clk);
        checkOutput("t1 c4 instr_ready", if1.instr_ready, 1);
        checkOutput("t1 c4 write_enable", if1.write_enable, 0);
        checkOutput("t1 c4 busy", if1.busy, 0);

        $display("[TB] ALU instruction, latency 3");
        @(negedge clk);
        if3.instr       = 16'h2F84;
        if3.instr_valid = 1'b1;
        checkOutput("t2 instr_ready", if3.instr_ready, 1);
        exp3.push_back(mkExp(1'b1, 4'hF, 8'd1, 4'h8, 4'h4, 4'h2));
        @(posedge clk);
        #1 if3.instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t2 c%0d RA1", c), if3.RA1, 8);
            checkOutput($sformatf("t2 c%0d RA2", c), if3.RA2, 4);
            checkOutput($sformatf("t2 c%0d write_enable", c), if3.write_enable, (c == 5));
        end

        $display("[TB] write-back stall");
        if1.wb_stall = 1'b1;
        applyStimulus(16'h3C56, mkExp(1'b1, 4'hC, 8'd2, 4'h5, 4'h6, 4'h3));
        repeat (2) @(negedge clk);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            checkOutput($sformatf("t3 c%0d write_enable", c), if1.write_enable, 0);
            checkOutput($sformatf("t3 c%0d busy", c), if1.busy, 1);
            checkOutput($sformatf("t3 c%0d WA", c), if1.WA, 4'hC);
        end
        if1.wb_stall = 1'b0;
        wrote = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if1.write_enable) wrote++;
        end
        checkOutput("t3 write pulses", wrote, 1);
        checkOutput("t3 instr_count", if1.instr_count, 2);
        checkOutput("t3 instr_ready", if1.instr_ready, 1);

        $display("[TB] NOP then HALT");
        pre = wePulses1;
        applyStimulus(16'h0000, mkExp(1'b0, 4'h0, 8'd3, 4'h0, 4'h0, 4'h0));
        applyStimulus(16'hF000, mkExp(1'b0, 4'h0, 8'd4, 4'h0, 4'h0, 4'h0));
        @(negedge clk);
        checkOutput("t4 halted", if1.halted, 1);
        checkOutput("t4 instr_ready", if1.instr_ready, 0);
        checkOutput("t4 busy", if1.busy, 0);
        checkOutput("t4 instr_count", if1.instr_count, 4);
        if1.instr       = 16'h1123;
        if1.instr_valid = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t4 still halted", if1.halted, 1);
        checkOutput("t4 count frozen", if1.instr_count, 4);
        checkOutput("t4 no launch", if1.alu_start, 0);
        if1.instr_valid = 1'b0;
        checkOutput("t4 no writes", wePulses1 - pre, 0);

        $display("[TB] reset during EXEC");
        pre = wePulses3;
        @(negedge clk);
        checkOutput("t5 instr_ready", if3.instr_ready, 1);
        if3.instr       = 16'h4321;
        if3.instr_valid = 1'b1;
        @(posedge clk);
        #1 if3.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5 in EXEC busy", if3.busy, 1);
        rst3 = 1'b1;
        @(negedge clk);
        checkOutput("t5 instr_ready", if3.instr_ready, 1);
        checkOutput("t5 flags", {if3.busy, if3.halted, if3.done, if3.write_enable, if3.alu_start}, 0);
        checkOutput("t5 addresses", {if3.RA1, if3.RA2, if3.WA, if3.alu_op}, 0);
        checkOutput("t5 instr_count", if3.instr_count, 0);
        rst3 = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("t5 no aborted write", wePulses3 - pre, 0);

        $display("[TB] 256 NOPs, counter wrap");
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        checkOutput("t6 count after reset", if1.instr_count, 0);
        checkOutput("t6 halted after reset", if1.halted, 0);
        for (int i = 0; i < 256; i++) begin
            exp1.push_back(mkExp(1'b0, 4'h0, 8'(i + 1), 4'h0, 4'h0, 4'h0));
        end
        @(negedge clk);
        if1.instr       = 16'h0000;
        if1.instr_valid = 1'b1;
        notReady = 0;
        for (int i = 0; i < 256; i++) begin
            if (!if1.instr_ready) notReady++;
            @(posedge clk);
            @(negedge clk);
        end
        if1.instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6 count wrapped", if1.instr_count, 0);
        checkOutput("t6 instr_ready never low", notReady, 0);
        checkOutput("dut1 expectations drained", exp1.size(), 0);
        checkOutput("dut3 expectations drained", exp3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
